// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI slave frame controller.
package spi_slv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StActive,
    StClose
  } state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int unsigned FRAME_CNT_W = 16;

  // S_WCHAR resets to this bit replicated across the character width
  localparam logic WCHAR_RST_FILL = 1'b1;

endpackage

// File: rtl/spi_slv_frame_ctrl_if.sv
// Host-side TX push / RX pop handshake bundle for the SPI slave frame controller.
interface spi_slv_frame_ctrl_if #(
  parameter int unsigned CHAR_NBITS = 32
);
  logic [CHAR_NBITS-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;
  logic [CHAR_NBITS-1:0] RX_DATA;
  logic                  RX_VALID;
  logic                  RX_READY;

  modport master (
    output TX_DATA, TX_VALID, RX_READY,
    input  TX_READY, RX_DATA, RX_VALID
  );

  modport slave (
    input  TX_DATA, TX_VALID, RX_READY,
    output TX_READY, RX_DATA, RX_VALID
  );
endinterface

// File: rtl/spi_slv_txfifo.sv
// Small synchronous FIFO with head-word lookahead; Depth must be a power of two.
module spi_slv_txfifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == DepthC);
  assign empty_o = (cnt_q == '0);
  // When full, a simultaneous pop frees the slot being written
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally modulo Depth
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AddrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AddrW'(1);
      cnt_q <= cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_slv_frame_ctrl.sv
// Frame sequencing controller for the SPI slave character transceiver.
// Optional build macro SPI_SLV_CTRL_STATS_EN adds saturating error-event counters.
module spi_slv_frame_ctrl
  import spi_slv_pkg::*;
#(
  parameter int unsigned CHAR_NBITS = 32,
  parameter int unsigned TXF_DEPTH  = 4
) (
  input  logic                   S_SYSCLK,
  input  logic                   S_RESET,
  input  logic                   C_ENABLE,
  input  logic [1:0]             C_MODE,
  input  logic                   C_REV,
  input  logic                   C_LOOP,
  input  logic [3:0]             C_CHAR_LEN,
  input  logic [CHAR_NBITS-1:0]  C_DUMMY,
  spi_slv_frame_ctrl_if.slave    host,
  output logic                   FRAME_DONE,
  output logic [FRAME_CNT_W-1:0] FRAME_CHARS,
  output logic                   ERR_UNDERRUN,
  output logic                   ERR_OVERRUN,
  input  logic                   ERR_CLR,
  output logic                   BUSY,
  output logic                   S_ENABLE,
  output logic                   S_CPOL,
  output logic                   S_CPHA,
  output logic                   S_LOOP,
  output logic                   S_REV,
  output logic [3:0]             S_CHAR_LEN,
  output logic [CHAR_NBITS-1:0]  S_WCHAR,
  input  logic                   S_CHAR_DONE,
  input  logic [CHAR_NBITS-1:0]  S_RCHAR,
  input  logic                   S_SPI_SEL
`ifdef SPI_SLV_CTRL_STATS_EN
  ,
  output logic [FRAME_CNT_W-1:0] STAT_UNDERRUNS,
  output logic [FRAME_CNT_W-1:0] STAT_OVERRUNS
`endif
);

  state_e                 state_q, state_d;
  logic [1:0]             sel_sync_q;
  logic [2:0]             done_sync_q;
  logic                   sel_lo, char_evt, entry, evt_act, frame_end;
  logic [1:0]             mode_q;
  logic                   rev_q, loop_q;
  logic [3:0]             char_len_q;
  logic [CHAR_NBITS-1:0]  wchar_q, wchar_d, fifo_head;
  logic                   cur_fifo_q, cur_fifo_d;
  logic                   fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d, frame_chars_q, frame_chars_d;
  logic [CHAR_NBITS-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   under_q, under_d, under_set;
  logic                   over_q, over_d, over_set;

  // Two-flop synchronisers plus one extra stage on done for rising-edge detection
  always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
    if (S_RESET) begin
      sel_sync_q  <= 2'b11;
      done_sync_q <= '0;
    end else begin
      sel_sync_q  <= {sel_sync_q[0], S_SPI_SEL};
      done_sync_q <= {done_sync_q[1:0], S_CHAR_DONE};
    end
  end

  assign sel_lo   = ~sel_sync_q[1];
  assign char_evt = done_sync_q[1] & ~done_sync_q[2];

  // State register
  always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
    if (S_RESET) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic; disable in ACTIVE is deferred until the frame closes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (C_ENABLE) state_d = StArmed;
      StArmed: begin
        if (!C_ENABLE)   state_d = StIdle;
        else if (sel_lo) state_d = StActive;
      end
      StActive: if (!sel_lo) state_d = StClose;
      StClose:  state_d = C_ENABLE ? StArmed : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    S_ENABLE   = (state_q != StIdle);
    BUSY       = (state_q == StActive);
    FRAME_DONE = (state_q == StClose);
  end

  assign entry     = (state_q == StArmed) && (state_d == StActive);
  assign frame_end = (state_q == StActive) && (state_d == StClose);
  assign evt_act   = char_evt && (state_q == StActive);

  // Transceiver configuration tracks C_ inputs only outside a frame
  always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
    if (S_RESET) begin
      mode_q     <= SPI_MODE0;
      rev_q      <= 1'b0;
      loop_q     <= 1'b0;
      char_len_q <= '0;
    end else if (state_q == StIdle || state_q == StArmed) begin
      mode_q     <= C_MODE;
      rev_q      <= C_REV;
      loop_q     <= C_LOOP;
      char_len_q <= C_CHAR_LEN;
    end
  end

  assign S_CPOL     = mode_q[1];
  assign S_CPHA     = mode_q[0];
  assign S_REV      = rev_q;
  assign S_LOOP     = loop_q;
  assign S_CHAR_LEN = char_len_q;

  assign fifo_push     = host.TX_VALID & host.TX_READY;
  assign host.TX_READY = ~fifo_full & ~S_RESET;

  spi_slv_txfifo #(
    .Width (CHAR_NBITS),
    .Depth (TXF_DEPTH)
  ) u_txfifo (
    .clk_i   (S_SYSCLK),
    .rst_i   (S_RESET),
    .push_i  (fifo_push),
    .wdata_i (host.TX_DATA),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // TX word selection: preview head in ARMED, commit (pop) at frame entry and each character
  always_comb begin
    fifo_pop   = 1'b0;
    wchar_d    = wchar_q;
    cur_fifo_d = cur_fifo_q;
    under_set  = evt_act && !cur_fifo_q;
    if (state_q == StArmed) wchar_d = fifo_empty ? C_DUMMY : fifo_head;
    if (entry || evt_act) begin
      fifo_pop   = ~fifo_empty;
      cur_fifo_d = ~fifo_empty;
      wchar_d    = fifo_empty ? C_DUMMY : fifo_head;
    end
  end

  // Frame character counter, saturating; snapshot taken as the frame closes
  always_comb begin
    cnt_d         = cnt_q;
    frame_chars_d = frame_chars_q;
    if (entry) cnt_d = '0;
    else if (evt_act && cnt_q != {FRAME_CNT_W{1'b1}}) cnt_d = cnt_q + FRAME_CNT_W'(1);
    if (frame_end) frame_chars_d = cnt_d;
  end

  // RX capture; a full holding register drops the new character
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    over_set   = 1'b0;
    if (rx_valid_q && host.RX_READY) rx_valid_d = 1'b0;
    if (char_evt) begin
      if (rx_valid_q && !host.RX_READY) begin
        over_set = 1'b1;
      end else begin
        rx_data_d  = S_RCHAR;
        rx_valid_d = 1'b1;
      end
    end
  end

  // Sticky error flags: a set in the same cycle as a clear wins
  always_comb begin
    under_d = under_set ? 1'b1 : (ERR_CLR ? 1'b0 : under_q);
    over_d  = over_set  ? 1'b1 : (ERR_CLR ? 1'b0 : over_q);
  end

  // Datapath registers
  always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
    if (S_RESET) begin
      wchar_q       <= {CHAR_NBITS{WCHAR_RST_FILL}};
      cur_fifo_q    <= 1'b0;
      cnt_q         <= '0;
      frame_chars_q <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      under_q       <= 1'b0;
      over_q        <= 1'b0;
    end else begin
      wchar_q       <= wchar_d;
      cur_fifo_q    <= cur_fifo_d;
      cnt_q         <= cnt_d;
      frame_chars_q <= frame_chars_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      under_q       <= under_d;
      over_q        <= over_d;
    end
  end

  assign S_WCHAR       = wchar_q;
  assign FRAME_CHARS   = frame_chars_q;
  assign host.RX_DATA  = rx_data_q;
  assign host.RX_VALID = rx_valid_q;
  assign ERR_UNDERRUN  = under_q;
  assign ERR_OVERRUN   = over_q;

`ifdef SPI_SLV_CTRL_STATS_EN
  logic [FRAME_CNT_W-1:0] stat_under_q, stat_over_q;

  // Saturating error-event counters; an event coinciding with a clear counts once
  always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
    if (S_RESET) begin
      stat_under_q <= '0;
      stat_over_q  <= '0;
    end else begin
      if (ERR_CLR) stat_under_q <= FRAME_CNT_W'(under_set);
      else if (under_set && stat_under_q != {FRAME_CNT_W{1'b1}})
        stat_under_q <= stat_under_q + FRAME_CNT_W'(1);
      if (ERR_CLR) stat_over_q <= FRAME_CNT_W'(over_set);
      else if (over_set && stat_over_q != {FRAME_CNT_W{1'b1}})
        stat_over_q <= stat_over_q + FRAME_CNT_W'(1);
    end
  end

  assign STAT_UNDERRUNS = stat_under_q;
  assign STAT_OVERRUNS  = stat_over_q;
`endif

endmodule
